// File: rtl/regfile_2r1w_param.sv
// Parametrised 2-read / 1-write register file for the CPU datapath.
// DEPTH = 2**ADDR_W words of DATA_W bits. Options: hardwired-zero entry 0,
// write-to-read bypass, registered read outputs. Also exposes the one-hot write strobe.
module regfile_2r1w_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int RD_REG   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_W-1:0]    rd_addr_a,
  input  logic [ADDR_W-1:0]    rd_addr_b,
  output logic [DATA_W-1:0]    rd_data_a,
  output logic [DATA_W-1:0]    rd_data_b,
  output logic [2**ADDR_W-1:0] wr_onehot
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;

  // Write address decode; entry 0 is masked out when it is hardwired to zero
  always_comb begin
    wr_onehot = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (wr_en && (wr_addr == ADDR_W'(i))) wr_onehot[i] = 1'b1;
    end
    if (ZERO_REG != 0) wr_onehot[0] = 1'b0;
  end

  // Storage: cleared asynchronously, written through the decoded strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (wr_onehot[i]) mem[i] <= wr_data;
      end
    end
  end

  // Port A select: the strobe bit already encodes "write to a writable address",
  // so it doubles as the bypass hit; zero entry overrides everything
  always_comb begin
    sel_a = mem[rd_addr_a];
    if ((BYPASS != 0) && wr_onehot[rd_addr_a]) sel_a = wr_data;
    if ((ZERO_REG != 0) && (rd_addr_a == '0)) sel_a = '0;
  end

  // Port B select, same rules as port A
  always_comb begin
    sel_b = mem[rd_addr_b];
    if ((BYPASS != 0) && wr_onehot[rd_addr_b]) sel_b = wr_data;
    if ((ZERO_REG != 0) && (rd_addr_b == '0)) sel_b = '0;
  end

  if (RD_REG != 0) begin : g_rd_reg
    // Registered read: capture selected values when rd_en, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data_a <= '0;
        rd_data_b <= '0;
      end else if (rd_en) begin
        rd_data_a <= sel_a;
        rd_data_b <= sel_b;
      end
    end
  end else begin : g_rd_comb
    logic unused_rd_en;
    assign unused_rd_en = rd_en;
    // Combinational read straight from the select logic
    always_comb begin
      rd_data_a = sel_a;
      rd_data_b = sel_b;
    end
  end

endmodule

// File: tb/tb_regfile_2r1w_param.sv
// Self-checking bench for regfile_2r1w_param. Three configurations share one stimulus:
//   u0: 32x32, zero reg, bypass, combinational read
//   u1: 32x32, no zero reg, no bypass, registered read
//   u2: 8x16,  zero reg, bypass, registered read
module tb_regfile_2r1w_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        rd_en = 1'b0;
  logic [4:0]  rd_addr_a = '0;
  logic [4:0]  rd_addr_b = '0;

  logic [31:0] rd_a0, rd_b0, rd_a1, rd_b1;
  logic [15:0] rd_a2, rd_b2;
  logic [31:0] oh0, oh1;
  logic [7:0]  oh2;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  regfile_2r1w_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1), .RD_REG(0)) u0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_a0), .rd_data_b(rd_b0), .wr_onehot(oh0));

  regfile_2r1w_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0), .RD_REG(1)) u1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_a1), .rd_data_b(rd_b1), .wr_onehot(oh1));

  regfile_2r1w_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1), .RD_REG(1)) u2 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr[2:0]), .wr_data(wr_data[15:0]),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a[2:0]), .rd_addr_b(rd_addr_b[2:0]),
    .rd_data_a(rd_a2), .rd_data_b(rd_b2), .wr_onehot(oh2));

  // ---------------- behavioural model ----------------
  logic [31:0] m0 [32];
  logic [31:0] m1 [32];
  logic [15:0] m2 [8];
  logic [31:0] q1a, q1b;
  logic [15:0] q2a, q2b;

  function automatic logic [31:0] rd0(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wr_en && a == wr_addr) return wr_data;
    return m0[a];
  endfunction

  function automatic logic [31:0] rd1(input logic [4:0] a);
    return m1[a];
  endfunction

  function automatic logic [15:0] rd2(input logic [2:0] a);
    if (a == 3'd0) return 16'd0;
    if (wr_en && a == wr_addr[2:0]) return wr_data[15:0];
    return m2[a];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin m0[i] = '0; m1[i] = '0; end
      for (int i = 0; i < 8; i++) m2[i] = '0;
      q1a = '0; q1b = '0; q2a = '0; q2b = '0;
    end else begin
      if (rd_en) begin
        q1a = rd1(rd_addr_a);      q1b = rd1(rd_addr_b);
        q2a = rd2(rd_addr_a[2:0]); q2b = rd2(rd_addr_b[2:0]);
      end
      if (wr_en) begin
        m1[wr_addr] = wr_data;
        if (wr_addr != 5'd0) m0[wr_addr] = wr_data;
        if (wr_addr[2:0] != 3'd0) m2[wr_addr[2:0]] = wr_data[15:0];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, mid-cycle
  always @(negedge clk) begin
    if (chk_en) begin
      chk("u0_rd_a", rd_a0, rd0(rd_addr_a));
      chk("u0_rd_b", rd_b0, rd0(rd_addr_b));
      chk("u1_rd_a", rd_a1, q1a);
      chk("u1_rd_b", rd_b1, q1b);
      chk("u2_rd_a", {16'd0, rd_a2}, {16'd0, q2a});
      chk("u2_rd_b", {16'd0, rd_b2}, {16'd0, q2b});
      chk("u0_onehot", oh0, wr_en ? ((32'd1 << wr_addr) & ~32'd1) : 32'd0);
      chk("u1_onehot", oh1, wr_en ? (32'd1 << wr_addr) : 32'd0);
      chk("u2_onehot", {24'd0, oh2}, {24'd0, wr_en ? ((8'd1 << wr_addr[2:0]) & 8'hFE) : 8'd0});
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cyc();
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc();
    chk_en = 1'b1;
    cyc();
    #3;
    chk("reset_u1_a", rd_a1, 32'd0);
    cyc();
    rst_n = 1'b1;

    // 1. fill with DEADBEEF, then asynchronous reset mid-cycle
    for (int i = 0; i < 32; i++) wr(5'(i), 32'hDEADBEEF);
    cyc();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr_a = 5'd9; rd_addr_b = 5'd9;
    #3;
    chk("fill_u0_r9", rd_a0, 32'hDEADBEEF);
    cyc();
    rst_n = 1'b0;
    #3;
    chk("async_rst_u0", rd_a0, 32'd0);
    chk("async_rst_u1", rd_a1, 32'd0);
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      cyc();
      rd_addr_a = 5'(i); rd_addr_b = 5'(31 - i);
      #3;
      chk("post_rst_u0_b", rd_b0, 32'd0);
    end

    // 2. write/read r7
    wr(5'd7, 32'h12345678);
    cyc();
    wr_en = 1'b0; rd_addr_a = 5'd7; rd_addr_b = 5'd7;
    #3;
    chk("r7_u0_a", rd_a0, 32'h12345678);
    chk("r7_u0_b", rd_b0, 32'h12345678);
    cyc();
    #3;
    chk("r7_u1_a", rd_a1, 32'h12345678);
    chk("r7_u2_b", {16'd0, rd_b2}, 32'h00005678);

    // 3. zero register
    wr(5'd0, 32'hFFFFFFFF);
    rd_addr_a = 5'd0; rd_addr_b = 5'd0;
    #3;
    chk("zero_u0_onehot", oh0, 32'd0);
    chk("zero_u1_onehot", oh1, 32'd1);
    chk("zero_u0_bypass", rd_a0, 32'd0);
    cyc();
    wr_en = 1'b0;
    #3;
    chk("zero_u1_old", rd_a1, 32'd0);
    cyc();
    #3;
    chk("zero_u1_new", rd_a1, 32'hFFFFFFFF);
    chk("zero_u0_read", rd_a0, 32'd0);

    // 4. bypass
    wr(5'd5, 32'h0000000A);
    wr(5'd5, 32'h0000000B);
    rd_addr_a = 5'd5; rd_addr_b = 5'd5;
    #3;
    chk("byp_u0_a", rd_a0, 32'h0000000B);
    chk("byp_u0_b", rd_b0, 32'h0000000B);
    cyc();
    wr_en = 1'b0;
    #3;
    chk("nobyp_u1_a", rd_a1, 32'h0000000A);
    chk("byp_u2_a", {16'd0, rd_a2}, 32'h0000000B);
    cyc();
    #3;
    chk("nobyp_u1_next", rd_a1, 32'h0000000B);

    // 5. registered read and hold
    wr(5'd3, 32'h00000055);
    wr(5'd4, 32'h00000066);
    cyc();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr_a = 5'd3;
    cyc();
    #3;
    chk("rdreg_u1_a", rd_a1, 32'h00000055);
    rd_en = 1'b0; rd_addr_a = 5'd4;
    cyc();
    #3;
    chk("rdreg_hold_u1", rd_a1, 32'h00000055);
    chk("rdreg_hold_u2", {16'd0, rd_a2}, 32'h00000055);
    chk("comb_u0_r4", rd_a0, 32'h00000066);

    // 6. decode sweep with bypass reads on every address
    rd_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      wr(5'(i), 32'h10000000 + 32'(i) * 32'h01010101);
      rd_addr_a = 5'(i); rd_addr_b = 5'((i + 31) % 32);
      #3;
      chk("sweep_u0_onehot", oh0, (i == 0) ? 32'd0 : (32'd1 << i));
      chk("sweep_u2_onehot", {24'd0, oh2}, (i % 8 == 0) ? 32'd0 : (32'd1 << (i % 8)));
    end
    cyc();
    wr_en = 1'b0;
    #3;
    chk("idle_u0_onehot", oh0, 32'd0);
    chk("idle_u2_onehot", {24'd0, oh2}, 32'd0);
    cyc();
    cyc();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
